// File: rtl/ram_dma_pkg.sv
// Shared widths and FSM state encoding for the RAM-to-RAM copy engine.
package ram_dma_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ram_dma_if.sv
// Request handshake plus single-port memory bus between a requester, the DMA and a RAM.
interface ram_dma_if;
  import ram_dma_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;
  logic              busy;
  logic              done;

  // Requester / memory side
  modport master (
    output start, src_addr, dst_addr, length, mem_out,
    input  mem_address, mem_in, mem_load, busy, done
  );

  // DMA engine side
  modport slave (
    input  start, src_addr, dst_addr, length, mem_out,
    output mem_address, mem_in, mem_load, busy, done
  );

endinterface

// File: rtl/ptr_reg_14.sv
// Loadable, wrapping incrementing address pointer.
module ptr_reg_14
  import ram_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] ptr_q;

  // Load has priority over increment; increment wraps naturally at the top address
  always_comb begin
    ptr_d = ptr_q;
    if (load)     ptr_d = d;
    else if (inc) ptr_d = ptr_q + ADDR_W'(1);
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign q = ptr_q;

endmodule

// File: rtl/ram_16K.sv
// 16K-word memory model: combinational read, write committed on the rising clock.
module ram_16K
  import ram_dma_pkg::*;
(
  input  logic              clock,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  assign data_out = mem[address];

  // Synchronous write port
  always_ff @(posedge clock) begin
    if (load) mem[address] <= data_in;
  end

endmodule

// File: rtl/ram_dma.sv
// Word-by-word memory copy engine: READ latches a source word, WRITE stores it, ascending order.
module ram_dma #(
  parameter int unsigned ADDR_W = ram_dma_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_dma_pkg::DATA_W
) (
  input  logic     clock,
  input  logic     reset_n,
  ram_dma_if.slave bus
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  ram_dma_pkg::state_e state_d;
  ram_dma_pkg::state_e state_q;
  logic [LEN_W-1:0]    remaining_d;
  logic [LEN_W-1:0]    remaining_q;
  logic [DATA_W-1:0]   data_d;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   src_ptr;
  logic [ADDR_W-1:0]   dst_ptr;
  logic                ptr_load;
  logic                ptr_inc;

  // Pointers load only when a non-empty copy is accepted; they advance after each write
  assign ptr_load = (state_q == ram_dma_pkg::ST_IDLE) && bus.start && (bus.length != '0);
  assign ptr_inc  = (state_q == ram_dma_pkg::ST_WRITE);

  ptr_reg_14 u_src_ptr (
    .clk   (clock),
    .rst_n (reset_n),
    .load  (ptr_load),
    .inc   (ptr_inc),
    .d     (bus.src_addr),
    .q     (src_ptr)
  );

  ptr_reg_14 u_dst_ptr (
    .clk   (clock),
    .rst_n (reset_n),
    .load  (ptr_load),
    .inc   (ptr_inc),
    .d     (bus.dst_addr),
    .q     (dst_ptr)
  );

  // Next-state, datapath updates and Moore output decode
  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    data_d          = data_q;
    bus.mem_address = '0;
    bus.mem_in      = '0;
    bus.mem_load    = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;

    unique case (state_q)
      ram_dma_pkg::ST_IDLE: begin
        if (bus.start) begin
          remaining_d = bus.length;
          state_d     = (bus.length == '0) ? ram_dma_pkg::ST_DONE : ram_dma_pkg::ST_READ;
        end
      end
      ram_dma_pkg::ST_READ: begin
        bus.busy        = 1'b1;
        bus.mem_address = src_ptr;
        data_d          = bus.mem_out;
        state_d         = ram_dma_pkg::ST_WRITE;
      end
      ram_dma_pkg::ST_WRITE: begin
        bus.busy        = 1'b1;
        bus.mem_address = dst_ptr;
        bus.mem_in      = data_q;
        bus.mem_load    = 1'b1;
        remaining_d     = remaining_q - LEN_W'(1);
        state_d         = (remaining_q == LEN_W'(1)) ? ram_dma_pkg::ST_DONE
                                                      : ram_dma_pkg::ST_READ;
      end
      ram_dma_pkg::ST_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = ram_dma_pkg::ST_IDLE;
      end
      default: state_d = ram_dma_pkg::ST_IDLE;
    endcase
  end

  // State, word counter and data holding register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ram_dma_pkg::ST_IDLE;
      remaining_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: attaches ram_16K, keeps a reference image of memory and copies into it.
module tb_ram_dma;
  import ram_dma_pkg::*;

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic clock = 1'b0;
  logic reset_n;

  ram_dma_if bus ();

  logic              tb_own;
  logic              tb_load;
  logic [ADDR_W-1:0] tb_addr;
  logic [DATA_W-1:0] tb_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_load;

  logic [DATA_W-1:0] ref_mem [DEPTH];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // Bench owns the memory port for preload and readback while the DMA is idle
  assign ram_addr    = tb_own ? tb_addr : bus.mem_address;
  assign ram_din     = tb_own ? tb_data : bus.mem_in;
  assign ram_load    = tb_own ? tb_load : bus.mem_load;
  assign bus.mem_out = ram_dout;

  ram_16K u_ram (
    .clock    (clock),
    .address  (ram_addr),
    .data_in  (ram_din),
    .load     (ram_load),
    .data_out (ram_dout)
  );

  ram_dma u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference copy: ascending, one word at a time, addresses modulo memory size
  task automatic ref_copy(input int src, input int dst, input int len);
    for (int i = 0; i < len; i++)
      ref_mem[(dst + i) % DEPTH] = ref_mem[(src + i) % DEPTH];
  endtask

  task automatic mem_write(input int a, input logic [DATA_W-1:0] v);
    tb_own = 1'b1;
    @(negedge clock);
    tb_addr = ADDR_W'(a);
    tb_data = v;
    tb_load = 1'b1;
    @(negedge clock);
    tb_load = 1'b0;
    ref_mem[a % DEPTH] = v;
  endtask

  // Reads the whole RAM back and reports how many words differ from the reference image
  task automatic scan_mem(output int bad, output int first, output logic [DATA_W-1:0] got_v,
                          output logic [DATA_W-1:0] exp_v);
    bad = 0; first = -1; got_v = '0; exp_v = '0;
    tb_own  = 1'b1;
    tb_load = 1'b0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      tb_addr = ADDR_W'(a);
      #1;
      if (ram_dout !== ref_mem[a]) begin
        if (bad == 0) begin first = a; got_v = ram_dout; exp_v = ref_mem[a]; end
        bad++;
      end
    end
    @(negedge clock);
  endtask

  // Issues one request and watches it to completion; optionally re-pulses start at cycle pulse_k
  task automatic copy_and_wait(input int src, input int dst, input int len, input int pulse_k,
                               output int lat, output int loads, output int busy_bad,
                               output int extra_done);
    int k = 0;
    int budget = 2 * len + 8;
    loads = 0; busy_bad = 0; extra_done = 0;
    tb_own = 1'b0;
    @(negedge clock);
    bus.start    = 1'b1;
    bus.src_addr = ADDR_W'(src);
    bus.dst_addr = ADDR_W'(dst);
    bus.length   = LEN_W'(len);
    do begin
      @(negedge clock);
      k++;
      bus.start = (k == pulse_k);
      if (k == pulse_k) begin
        bus.src_addr = ADDR_W'(src + 4000);
        bus.dst_addr = ADDR_W'(dst + 4000);
        bus.length   = LEN_W'(2);
      end
      if (bus.mem_load === 1'b1) loads++;
      if (bus.busy !== 1'b1) busy_bad++;
    end while (bus.done !== 1'b1 && k < budget);
    lat = k;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.done !== 1'b0) extra_done++;
      if (bus.busy !== 1'b0) busy_bad++;
      if (bus.mem_load === 1'b1) loads++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.mem_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", bus.mem_load); end
    checks++; if (bus.mem_address !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.mem_address); end
    checks++; if (bus.mem_in !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.mem_in); end
  endtask

  task automatic test_basic();
    int lat, loads, bb, ed, bad, first;
    logic [DATA_W-1:0] g, e;
    for (int i = 0; i < 4; i++) mem_write(100 + i, DATA_W'($urandom));
    ref_copy(100, 200, 4);
    copy_and_wait(100, 200, 4, 0, lat, loads, bb, ed);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
    checks++; if (loads !== 4) begin errors++; $display("FAIL basic_writes: got %0d want 4", loads); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL basic_busy: %0d bad cycles want 0", bb); end
    checks++; if (ed !== 0) begin errors++; $display("FAIL basic_done_pulse: %0d extra want 0", ed); end
    scan_mem(bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_mem: %0d words at %0d got %h want %h", bad, first, g, e); end
  endtask

  task automatic test_zero_len();
    int lat, loads, bb, ed, bad, first;
    logic [DATA_W-1:0] g, e;
    copy_and_wait(300, 301, 0, 0, lat, loads, bb, ed);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", lat); end
    checks++; if (loads !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", loads); end
    checks++; if (bb !== 0 || ed !== 0) begin errors++; $display("FAIL zero_handshake: busy_bad %0d extra_done %0d want 0 0", bb, ed); end
    scan_mem(bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL zero_mem: %0d words at %0d got %h want %h", bad, first, g, e); end
  endtask

  task automatic test_wrap();
    int lat, loads, bb, ed, bad, first;
    logic [DATA_W-1:0] g, e;
    mem_write(16382, 16'd1);
    mem_write(16383, 16'd2);
    mem_write(0, 16'd3);
    ref_copy(16382, 5, 3);
    copy_and_wait(16382, 5, 3, 0, lat, loads, bb, ed);
    checks++; if (lat !== 7) begin errors++; $display("FAIL wrap_latency: got %0d want 7", lat); end
    scan_mem(bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_mem: %0d words at %0d got %h want %h", bad, first, g, e); end
  endtask

  task automatic test_overlap();
    int lat, loads, bb, ed, bad, first;
    logic [DATA_W-1:0] g, e;
    mem_write(10, 16'd7);
    ref_copy(10, 11, 3);
    copy_and_wait(10, 11, 3, 0, lat, loads, bb, ed);
    checks++; if (ref_mem[13] !== 16'd7) begin errors++; $display("FAIL overlap_model: got %h want 0007", ref_mem[13]); end
    scan_mem(bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL overlap_mem: %0d words at %0d got %h want %h", bad, first, g, e); end
  endtask

  task automatic test_busy_ignore();
    int lat, loads, bb, ed, bad, first;
    logic [DATA_W-1:0] g, e;
    ref_copy(300, 900, 3);
    copy_and_wait(300, 900, 3, 3, lat, loads, bb, ed);
    checks++; if (lat !== 7) begin errors++; $display("FAIL ignore_latency: got %0d want 7", lat); end
    checks++; if (loads !== 3) begin errors++; $display("FAIL ignore_writes: got %0d want 3", loads); end
    checks++; if (ed !== 0 || bb !== 0) begin errors++; $display("FAIL ignore_handshake: extra_done %0d busy_bad %0d want 0 0", ed, bb); end
    scan_mem(bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL ignore_mem: %0d words at %0d got %h want %h", bad, first, g, e); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int bad, first;
    logic [DATA_W-1:0] g, e;
    for (int i = 0; i < 4; i++) begin
      mem_write(700 + i, DATA_W'(16'h1111 * (i + 1)));
      mem_write(800 + i, 16'h0000);
    end
    tb_own = 1'b0;
    @(negedge clock);
    bus.start    = 1'b1;
    bus.src_addr = ADDR_W'(700);
    bus.dst_addr = ADDR_W'(800);
    bus.length   = LEN_W'(4);
    do begin
      @(negedge clock);
      bus.start = 1'b0;
      k++;
    end while (k < 4);
    checks++; if (bus.mem_load !== 1'b1) begin errors++; $display("FAIL midrst_second_write: load got %b want 1", bus.mem_load); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.mem_load !== 1'b0) begin errors++; $display("FAIL midrst_load: got %b want 0", bus.mem_load); end
    checks++; if (bus.busy !== 1'b0 || bus.mem_address !== '0) begin errors++; $display("FAIL midrst_outputs: busy %b addr %h want 0 0", bus.busy, bus.mem_address); end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy %b done %b want 0 0", bus.busy, bus.done); end
    ref_mem[800] = ref_mem[700];
    scan_mem(bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_mem: %0d words at %0d got %h want %h", bad, first, g, e); end
  endtask

  task automatic test_random();
    int lat, loads, bb, ed, bad, first, src, dst, len;
    logic [DATA_W-1:0] g, e;
    for (int n = 0; n < 6; n++) begin
      src = int'($urandom_range(0, DEPTH - 1));
      dst = (n == 2) ? (src + 1) % int'(DEPTH) : int'($urandom_range(0, DEPTH - 1));
      len = int'($urandom_range(1, 24));
      ref_copy(src, dst, len);
      copy_and_wait(src, dst, len, 0, lat, loads, bb, ed);
      checks++; if (lat !== 2 * len + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, 2 * len + 1); end
      checks++; if (loads !== len || ed !== 0) begin errors++; $display("FAIL rand_writes[%0d]: writes %0d extra_done %0d want %0d 0", n, loads, ed, len); end
    end
    scan_mem(bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_mem: %0d words at %0d got %h want %h", bad, first, g, e); end
  endtask

  initial begin
    reset_n      = 1'b0;
    tb_own       = 1'b1;
    tb_load      = 1'b0;
    tb_addr      = '0;
    tb_data      = '0;
    bus.start    = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.length   = '0;
    test_reset();
    @(negedge clock);
    reset_n = 1'b1;
    // Give every word a known random value so the whole image can be compared
    tb_load = 1'b1;
    for (int a = 0; a < int'(DEPTH); a++) begin
      tb_addr    = ADDR_W'(a);
      tb_data    = DATA_W'($urandom);
      ref_mem[a] = tb_data;
      @(negedge clock);
    end
    tb_load = 1'b0;
    test_basic();
    test_zero_len();
    test_wrap();
    test_overlap();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
